htif_axi_bridge: RTL

- Parametrised AXI4 slave that bridges the ARM PS general-purpose master port to the Rocket host-target interface (HTIF).
- Provides host_in/host_out FIFOs with width packing, occupancy/free registers and a level-held core reset register.
- Supports independent AW/W arrival, burst rejection and full AXI response codes.
- Sits between the Zynq M_AXI port and the Top io_host_* ports, in host_clk domain.

---
 rtl/htif_axi_bridge.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/htif_axi_bridge.sv
// AXI4 slave bridging the PS general-purpose master port onto the Rocket HTIF
// host_in/host_out streams, with word<->chunk packing and a level core reset.
module htif_axi_bridge #(
  parameter int HOST_W = 16,
  parameter int DEPTH  = 32,
  parameter int ID_W   = 12
) (
  input  logic              host_clk,
  input  logic              reset,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [7:0]        s_axi_awlen,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wlast,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [31:0]       s_axi_araddr,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [7:0]        s_axi_arlen,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              host_in_valid,
  input  logic              host_in_ready,
  output logic [HOST_W-1:0] host_in_bits,
  input  logic              host_out_valid,
  output logic              host_out_ready,
  input  logic [HOST_W-1:0] host_out_bits,
  output logic              reset_cpu,
  output logic [2:0]        w_state_dbg,
  output logic              r_state_dbg
);
  // Every channel follows AXI valid/ready: a transfer happens on the rising
  // host_clk edge where both are high; valid never waits on ready.
  localparam int CHUNKS = 32 / HOST_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [4:0]        w_idx_q, w_idx_d;
  logic [ID_W-1:0]   bid_q, bid_d, rid_q, rid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              reset_cpu_q, reset_cpu_d, r_pop_q, r_pop_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [31:0]       rdata_q, rdata_d, out_sr_q, out_sr_d;
  logic [PW-1:0]     in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [PW-1:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [IW-1:0]     in_idx_q, in_idx_d, out_idx_q, out_idx_d;
  logic [31:0]       in_mem [DEPTH];
  logic [31:0]       out_mem [DEPTH];

  logic in_full, in_empty, out_full, out_empty, in_push, in_pop, out_push, out_pop;
  logic w_hs, r_hs, out_last;
  logic [31:0] in_head;
  logic [31+HOST_W:0] out_cat;
  logic unused_ok;

  assign unused_ok = ^{s_axi_awaddr[31:7], s_axi_awaddr[1:0],
                       s_axi_araddr[31:7], s_axi_araddr[1:0]};

  assign in_full   = in_cnt_q == CW'(DEPTH);
  assign in_empty  = in_cnt_q == '0;
  assign out_full  = out_cnt_q == CW'(DEPTH);
  assign out_empty = out_cnt_q == '0;
  assign in_head   = in_mem[in_rd_q];
  assign out_last  = out_idx_q == IW'(CHUNKS - 1);
  assign out_cat   = {host_out_bits, out_sr_q};

  assign host_in_valid = !in_empty;
  assign host_in_bits  = in_head[HOST_W*in_idx_q +: HOST_W];
  assign in_pop        = host_in_valid && host_in_ready && in_idx_q == IW'(CHUNKS - 1);

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign r_hs           = r_state_q == R_DATA && s_axi_rready;
  assign out_pop        = r_hs && r_pop_q;
  assign host_out_ready = !(out_last && out_full && !out_pop);
  assign out_push       = host_out_valid && host_out_ready && out_last;

  assign s_axi_wready = (w_state_q == W_DRAIN) ||
                        (w_state_q == W_DATA && !(w_idx_q == 5'h00 && in_full && !in_pop));
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign in_push = w_state_q == W_DATA && w_hs && w_idx_q == 5'h00;

  assign s_axi_awready = w_state_q == W_IDLE;
  assign s_axi_bvalid  = w_state_q == W_RESP;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = r_state_q == R_IDLE;
  assign s_axi_rvalid  = r_state_q == R_DATA;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = r_cnt_q == 8'd0;
  assign reset_cpu     = reset_cpu_q;
  assign w_state_dbg   = w_state_q;
  assign r_state_dbg   = r_state_q;

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    reset_cpu_d = reset_cpu_q;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid) begin
        w_idx_d   = s_axi_awaddr[6:2];
        bid_d     = s_axi_awid;
        w_state_d = (s_axi_awlen == 8'd0) ? W_DATA : W_DRAIN;
      end
      W_DATA: if (w_hs) begin
        if (w_idx_q == 5'h1f) reset_cpu_d = s_axi_wdata[0];
        bresp_d   = OKAY;
        w_state_d = W_RESP;
      end
      // Bursts are consumed without side effects and rejected.
      W_DRAIN: if (w_hs && s_axi_wlast) begin
        bresp_d   = SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_pop_d   = r_pop_q;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
        r_state_d = R_DATA;
        rid_d     = s_axi_arid;
        r_cnt_d   = s_axi_arlen;
        rdata_d   = '0;
        rresp_d   = OKAY;
        r_pop_d   = 1'b0;
        if (s_axi_arlen != 8'd0) rresp_d = SLVERR;
        else begin
          case (s_axi_araddr[6:2])
            5'h00: rdata_d = 32'(out_cnt_q);
            5'h01: if (out_empty) rresp_d = SLVERR;
                   else begin
                     rdata_d = out_mem[out_rd_q];
                     r_pop_d = 1'b1;
                   end
            5'h02: rdata_d = 32'(DEPTH) - 32'(in_cnt_q);
            5'h03: rdata_d = {29'b0, reset_cpu_q, out_empty, in_full};
            default: rdata_d = '0;
          endcase
        end
      end
      R_DATA: if (s_axi_rready) begin
        if (r_cnt_q == 8'd0) begin
          r_state_d = R_IDLE;
          r_pop_d   = 1'b0;
        end else r_cnt_d = r_cnt_q - 8'd1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    in_wr_d   = in_wr_q + PW'(in_push);
    in_rd_d   = in_rd_q + PW'(in_pop);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_wr_d  = out_wr_q + PW'(out_push);
    out_rd_d  = out_rd_q + PW'(out_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    out_sr_d  = out_sr_q;
    if (host_in_valid && host_in_ready)
      in_idx_d = in_pop ? '0 : in_idx_q + IW'(1);
    if (host_out_valid && host_out_ready) begin
      out_sr_d  = out_cat[31+HOST_W:HOST_W];
      out_idx_d = out_last ? '0 : out_idx_q + IW'(1);
    end
  end

  always_ff @(posedge host_clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      w_idx_q     <= '0;
      bid_q       <= '0;
      bresp_q     <= OKAY;
      reset_cpu_q <= 1'b1;
      rid_q       <= '0;
      r_cnt_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      r_pop_q     <= 1'b0;
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_cnt_q    <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      out_sr_q    <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      w_idx_q     <= w_idx_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      reset_cpu_q <= reset_cpu_d;
      rid_q       <= rid_d;
      r_cnt_q     <= r_cnt_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      r_pop_q     <= r_pop_d;
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      in_cnt_q    <= in_cnt_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      out_sr_q    <= out_sr_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define validity.
  always_ff @(posedge host_clk) begin
    if (in_push)  in_mem[in_wr_q]   <= s_axi_wdata;
    if (out_push) out_mem[out_wr_q] <= out_sr_d;
  end
endmodule
